// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI responder.
// Contents: FSM state type, default frame geometry and the field layout of
// the optional status word (built only when ADC_RESP_STATUS_EN is defined).
package adc_spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned DefWordW = 16;
    localparam int unsigned DefWords = 8;

    // Status word: frame counter in the top bits, stale flag in bit 0.
    localparam int unsigned StatusCntW     = 8;
    localparam int unsigned StatusStaleBit = 0;

endpackage

// File: rtl/adc_sample_stage.sv
// One-entry valid/ready staging buffer for sample frames.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   data_i/valid_i  incoming frame and its valid
//   ready_o         buffer empty (accepts data_i when valid_i is high)
//   take_i          consume the buffered frame (only meaningful when full_o)
//   data_o, full_o  buffered frame and occupancy
module adc_sample_stage #(
    parameter int unsigned FRAME_BITS = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [FRAME_BITS-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  take_i,
    output logic [FRAME_BITS-1:0] data_o,
    output logic                  full_o
);

    logic                  full_q, full_d;
    logic [FRAME_BITS-1:0] data_q, data_d;

    // take needs a full buffer and a load needs an empty one, so they never collide.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (take_i) begin
            full_d = 1'b0;
        end
        if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = !full_q;
    assign data_o  = data_q;
    assign full_o  = full_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC-side SPI responder: shifts a staged sample frame out on SDO1 during a
// SYNC1-low transfer and captures the master's first word from SDI1.
// Ports:
//   SCLK, RST_N        SPI clock (rising edge), asynchronous active-low reset
//   SYNC1              active-low frame select
//   SDI1 / SDO1        serial in / out, MSB first
//   SAMPLE_IN/VALID    next frame from the parallel source; SAMPLE_READY = staging empty
//   CMD_WORD/CMD_VALID last captured command word and its one-cycle update pulse
//   FRAME_DONE         one-cycle pulse after a full frame has been shifted
//   BUSY               transfer in progress (SHIFT or DONE)
// Optional feature: define ADC_RESP_STATUS_EN to replace the last word of each
// frame by {frame_count[7:0], 7'b0, stale}.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int unsigned WORD_W = DefWordW,
    parameter int unsigned WORDS  = DefWords
) (
    input  logic                      SCLK,
    input  logic                      RST_N,
    input  logic                      SYNC1,
    input  logic                      SDI1,
    output logic                      SDO1,
    input  logic [WORD_W*WORDS-1:0]   SAMPLE_IN,
    input  logic                      SAMPLE_VALID,
    output logic                      SAMPLE_READY,
    output logic [WORD_W-1:0]         CMD_WORD,
    output logic                      CMD_VALID,
    output logic                      FRAME_DONE,
    output logic                      BUSY
);

    localparam int unsigned FrameBits = WORD_W * WORDS;
    localparam int unsigned CntW      = $clog2(FrameBits + 1);
    localparam logic [CntW-1:0] WordCnt  = CntW'(WORD_W);
    localparam logic [CntW-1:0] FrameCnt = CntW'(FrameBits);

    state_e                 state_q, state_d;
    logic [FrameBits-1:0]   frame_q, frame_d;
    logic [FrameBits-1:0]   shreg_q, shreg_d;
    logic                   sdo_q, sdo_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0]      sdi_q, sdi_d;
    logic [WORD_W-1:0]      cmd_word_q, cmd_word_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic [FrameBits-1:0]   tx;
`ifdef ADC_RESP_STATUS_EN
    logic                   stale_q, stale_d;
    logic [StatusCntW-1:0]  fcnt_q, fcnt_d;
    logic [WORD_W-1:0]      status;
`endif

    logic                   stage_take;
    logic                   stage_full;
    logic [FrameBits-1:0]   stage_data;

    adc_sample_stage #(
        .FRAME_BITS (FrameBits)
    ) u_stage (
        .clk_i   (SCLK),
        .rst_ni  (RST_N),
        .data_i  (SAMPLE_IN),
        .valid_i (SAMPLE_VALID),
        .ready_o (SAMPLE_READY),
        .take_i  (stage_take),
        .data_o  (stage_data),
        .full_o  (stage_full)
    );

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        shreg_d      = shreg_q;
        sdo_d        = sdo_q;
        cnt_d        = cnt_q;
        sdi_d        = sdi_q;
        cmd_word_d   = cmd_word_q;
        cmd_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        stage_take   = 1'b0;
        tx           = frame_q;
`ifdef ADC_RESP_STATUS_EN
        stale_d      = stale_q;
        fcnt_d       = fcnt_q;
        status       = '0;
`endif
        unique case (state_q)
            StIdle: begin
                sdo_d = 1'b0;
                if (!SYNC1) begin
                    // No fresh sample staged: resend the previous frame and flag it stale.
                    stage_take = stage_full;
                    frame_d    = stage_full ? stage_data : frame_q;
                    tx         = frame_d;
`ifdef ADC_RESP_STATUS_EN
                    stale_d = !stage_full;
                    status[WORD_W-1 -: StatusCntW] = fcnt_q;
                    status[StatusStaleBit]         = stale_d;
                    tx[WORD_W-1:0]                 = status;
`endif
                    sdo_d   = tx[FrameBits-1];
                    shreg_d = tx << 1;
                    sdi_d   = {{(WORD_W-1){1'b0}}, SDI1};
                    cnt_d   = CntW'(1);
                    state_d = StShift;
                end
            end
            StShift: begin
                // cnt_q counts edges already taken; the word and the frame complete
                // one edge after their last bit was presented.
                if (cnt_q == WordCnt) begin
                    cmd_word_d  = sdi_q;
                    cmd_valid_d = 1'b1;
                end
                if (cnt_q == FrameCnt) begin
                    frame_done_d = 1'b1;
`ifdef ADC_RESP_STATUS_EN
                    fcnt_d = fcnt_q + 1'b1;
`endif
                    sdo_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    sdo_d   = shreg_q[FrameBits-1];
                    shreg_d = shreg_q << 1;
                    if (cnt_q < WordCnt) begin
                        sdi_d = {sdi_q[WORD_W-2:0], SDI1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                sdo_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Deselect always wins and returns to idle.
        if (SYNC1) begin
            state_d = StIdle;
            sdo_d   = 1'b0;
        end
    end

    always_ff @(posedge SCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= StIdle;
            frame_q      <= '0;
            shreg_q      <= '0;
            sdo_q        <= 1'b0;
            cnt_q        <= '0;
            sdi_q        <= '0;
            cmd_word_q   <= '0;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef ADC_RESP_STATUS_EN
            stale_q      <= 1'b0;
            fcnt_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            shreg_q      <= shreg_d;
            sdo_q        <= sdo_d;
            cnt_q        <= cnt_d;
            sdi_q        <= sdi_d;
            cmd_word_q   <= cmd_word_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_done_q <= frame_done_d;
`ifdef ADC_RESP_STATUS_EN
            stale_q      <= stale_d;
            fcnt_q       <= fcnt_d;
`endif
        end
    end

    assign SDO1       = sdo_q;
    assign CMD_WORD   = cmd_word_q;
    assign CMD_VALID  = cmd_valid_q;
    assign FRAME_DONE = frame_done_q;
    assign BUSY       = (state_q != StIdle);

endmodule
